axi_adc_jesd204_pn_sweep: RTL and testbench
===========================================

# axi_adc_jesd204_pn_sweep

PN-test sequencer for the JESD204 ADC channel datapath, living in the up_clk domain beside the per-channel register blocks. On a start request it walks channels 0..NUM_CHANNELS-1, acting as a master on the up register bus. For each channel it programs the PN monitor sequence select, waits for lock, then checks for a clean error-free window. It reports a per-channel pass mask, letting software or a bring-up FSM qualify link data integrity in one command.

## Interface
- NUM_CHANNELS, 4, channels swept (1..16)
- SETTLE_CYCLES, 1024, up_clk cycles allowed for PN lock after the select write is acked (>=1)
- CHECK_CYCLES, 4096, up_clk cycles of error-free observation required (>=1)
- up_clk  in  1  sole clock
- up_rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle sweep request; ignored while busy
- pnseq_sel  in  4  sequence select written to every channel; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at sweep end
- pass_mask  out  NUM_CHANNELS  bit n = channel n passed; valid when busy low
- up_wreq  out  1  write request pulse
- up_waddr  out  14  write address
- up_wdata  out  32  write data
- up_wack  in  1  write acknowledge pulse
- up_adc_pn_oos  in  NUM_CHANNELS  per-channel out-of-sync status
- up_adc_pn_err  in  NUM_CHANNELS  per-channel error status
- ack_timeout  out  1  sticky; set if any write went unacked (PN_SWEEP_ACK_TIMEOUT_EN only; tied 0 otherwise)

## Operation
- States: IDLE, WRITE, WAIT_ACK, SETTLE, CHECK, NEXT, DONE.
- IDLE, start=1:
  - latch pnseq_sel
  - clear pass_mask and ch index
  - go to WRITE
- WRITE:
  - up_wreq=1 for exactly one cycle
  - up_waddr = 14'h0100 + ch*16 + 14'h6
  - up_wdata = {12'd0, sel, 16'd0}
  - go to WAIT_ACK
- WAIT_ACK:
  - up_waddr and up_wdata held stable
  - on up_wack: load counter with SETTLE_CYCLES-1, go to SETTLE
- SETTLE:
  - count down to 0
  - at 0: if up_adc_pn_oos[ch]=1, record fail and go to NEXT; else load CHECK_CYCLES-1 and go to CHECK
- CHECK:
  - any cycle with up_adc_pn_oos[ch] or up_adc_pn_err[ch] high records fail; remaining window is still counted out
  - at 0: pass_mask[ch] = !fail
  - go to NEXT
- NEXT:
  - clear fail flag
  - if ch==NUM_CHANNELS-1, go to DONE; else ch+1, go to WRITE
- DONE: done=1 for one cycle, go to IDLE.
- Counter width: $clog2(max(SETTLE_CYCLES, CHECK_CYCLES, 64)+1). ch width: $clog2(NUM_CHANNELS) (min 1).
- up_wack outside WAIT_ACK is ignored.

## Timing
- Reset values:
  - state=IDLE
  - busy, done, up_wreq, ack_timeout = 0
  - up_waddr, up_wdata, pass_mask = 0
- start accepted in cycle t: busy=1 and up_wreq=1 in cycle t+1.
- up_wack in the same cycle as up_wreq is invalid by bus rule; the earliest wack is t+2.
- Per-channel duration: 1 + ack latency + SETTLE_CYCLES + CHECK_CYCLES + 1 cycles (pass path).
- done and busy falling occur in the same cycle; pass_mask is final in that cycle.
- start coincident with done: ignored.
- up_rstn asserted mid-sweep: immediate return to IDLE with all outputs at reset values; any in-flight write is abandoned.

## Configuration
- PN_SWEEP_ACK_TIMEOUT_EN defined: WAIT_ACK loads a 64-cycle counter. On expiry with no wack:
  - channel marked fail
  - ack_timeout set (sticky until reset or next accepted start)
  - go to NEXT
- Not defined: WAIT_ACK waits indefinitely; ack_timeout is constant 0.

## Structure
- Shared package axi_adc_jesd204_pkg holds:
  - channel register base 14'h0100
  - channel stride 16
  - CNTRL_3 offset 14'h6
  - pnseq field LSB 16
  - state enum encoding
- One sub-module: axi_adc_jesd204_pn_sweep_timer, a loadable down-counter with zero flag, shared by SETTLE, CHECK and ack timeout.

## Test plan
- Basic pass (NUM_CHANNELS=4, SETTLE=8, CHECK=16): start with sel=4'h1, wack 2 cycles after each wreq, oos/err all 0 -> four writes to addresses 0x106, 0x116, 0x126, 0x136 with wdata 0x00010000; done at t = 4*(1+2+8+16+1)+1; pass_mask=4'hF.
- Lock failure: oos[2]=1 throughout -> pass_mask=4'hB; channel 2 skips CHECK, so done arrives 16 cycles earlier than basic.
- Single error: err[1] pulses 1 cycle mid-CHECK -> pass_mask=4'hD; timing identical to basic.
- Busy guard/reset: start pulsed again during channel 1 -> ignored, one sweep only; then up_rstn low during SETTLE -> busy=0, up_wreq=0, pass_mask=0 next cycle.
- Ack timeout (macro on): wack withheld for channel 0 -> after 64 cycles ack_timeout=1, pass_mask[0]=0, and the sweep proceeds to 0x116.

Source files
------------

// File: rtl/axi_adc_jesd204_pkg.sv
// Shared definitions for the JESD204 ADC PN sweep sequencer.
// Holds the channel register map constants, the sweep FSM state encoding and
// small helpers that build the CNTRL_3 write address and data words.
package axi_adc_jesd204_pkg;

  localparam logic [13:0] CH_REG_BASE        = 14'h0100;
  localparam int unsigned CH_REG_STRIDE      = 16;
  localparam logic [13:0] CNTRL_3_OFFSET     = 14'h0006;
  localparam int unsigned PNSEQ_LSB          = 16;
  localparam int unsigned ACK_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_CHECK    = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } sweep_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  // CNTRL_3 register address of channel ch.
  function automatic logic [13:0] cntrl3_addr(input logic [3:0] ch);
    cntrl3_addr = CH_REG_BASE + (14'(ch) * 14'(CH_REG_STRIDE)) + CNTRL_3_OFFSET;
  endfunction

  // CNTRL_3 write data carrying the PN sequence select.
  function automatic logic [31:0] pnseq_wdata(input logic [3:0] sel);
    pnseq_wdata = 32'(sel) << PNSEQ_LSB;
  endfunction

endpackage

// File: rtl/axi_adc_jesd204_pn_sweep_if.sv
// up register-bus write channel used by the PN sweep sequencer.
//   up_wreq  : write request pulse (master -> slave)
//   up_waddr : 14-bit write address (master -> slave)
//   up_wdata : 32-bit write data (master -> slave)
//   up_wack  : write acknowledge pulse (slave -> master)
interface axi_adc_jesd204_pn_sweep_if;
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;

  modport master (output up_wreq, output up_waddr, output up_wdata, input up_wack);
  modport slave  (input up_wreq, input up_waddr, input up_wdata, output up_wack);
endinterface

// File: rtl/axi_adc_jesd204_pn_sweep_timer.sv
// Loadable down-counter with zero flag. Shared by the lock-settle window, the
// error-free check window and the optional write-ack timeout.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   load_i        : load load_val_i this cycle (wins over counting)
//   load_val_i    : value to load
//   zero_o        : counter is zero; the counter rests at zero
module axi_adc_jesd204_pn_sweep_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Counter register: load, else decrement until zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/axi_adc_jesd204_pn_sweep.sv
// PN-test sequencer: on start, walks every channel, writes the PN sequence
// select into its CNTRL_3 register over the up bus, waits for PN lock, then
// requires an error-free observation window. Reports a per-channel pass mask.
// Ports:
//   up_clk, up_rstn          : clock, asynchronous active-low reset
//   start, pnseq_sel         : sweep request and sequence select
//   busy, done, pass_mask    : sweep status and result
//   up_bus (master)          : register write channel
//   up_adc_pn_oos/_err       : per-channel PN monitor status
//   ack_timeout              : sticky write-ack timeout flag
// Optional feature: define PN_SWEEP_ACK_TIMEOUT_EN to bound each write-ack
// wait to 64 cycles; otherwise the wait is unbounded and ack_timeout is 0.
module axi_adc_jesd204_pn_sweep
  import axi_adc_jesd204_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CHECK_CYCLES  = 4096
) (
  input  logic                        up_clk,
  input  logic                        up_rstn,
  input  logic                        start,
  input  logic [3:0]                  pnseq_sel,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_CHANNELS-1:0]     pass_mask,
  axi_adc_jesd204_pn_sweep_if.master  up_bus,
  input  logic [NUM_CHANNELS-1:0]     up_adc_pn_oos,
  input  logic [NUM_CHANNELS-1:0]     up_adc_pn_err,
  output logic                        ack_timeout
);

  localparam int unsigned CNT_W = $clog2(max3(SETTLE_CYCLES, CHECK_CYCLES, 64) + 1);
  localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  sweep_state_e            state_q;
  logic [CH_W-1:0]         ch_q;
  logic [3:0]              sel_q;
  logic                    fail_q;
  logic                    busy_q;
  logic                    done_q;
  logic [NUM_CHANNELS-1:0] pass_mask_q;
  logic                    wreq_q;
  logic [13:0]             waddr_q;
  logic [31:0]             wdata_q;

  logic                    tmr_load_d;
  logic [CNT_W-1:0]        tmr_val_d;
  logic                    tmr_zero;
  logic                    ch_oos_d;
  logic                    ch_err_d;
  logic                    ch_last_d;
  logic [CH_W-1:0]         ch_nxt_d;

  assign ch_oos_d  = up_adc_pn_oos[ch_q];
  assign ch_err_d  = up_adc_pn_err[ch_q];
  assign ch_last_d = (ch_q == CH_W'(NUM_CHANNELS - 1));
  assign ch_nxt_d  = ch_q + CH_W'(1'b1);

  axi_adc_jesd204_pn_sweep_timer #(.W(CNT_W)) u_timer (
    .clk_i      (up_clk),
    .rst_ni     (up_rstn),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .zero_o     (tmr_zero)
  );

  // Timer load control: the window counters are loaded on the cycle that
  // leaves the previous phase so the new phase starts at N-1.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = {CNT_W{1'b0}};
    case (state_q)
      ST_WRITE: begin
`ifdef PN_SWEEP_ACK_TIMEOUT_EN
        tmr_load_d = 1'b1;
        tmr_val_d  = CNT_W'(ACK_TIMEOUT_CYCLES - 1);
`else
        tmr_load_d = 1'b0;
`endif
      end
      ST_WAIT_ACK: begin
        if (up_bus.up_wack) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero && !ch_oos_d) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = CNT_W'(CHECK_CYCLES - 1);
        end else begin
          tmr_load_d = 1'b0;
        end
      end
      default: tmr_load_d = 1'b0;
    endcase
  end

`ifdef PN_SWEEP_ACK_TIMEOUT_EN
  logic ack_timeout_q;
`endif

  // Sweep FSM with registered outputs; bus outputs are set on entry to WRITE.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q     <= ST_IDLE;
      ch_q        <= {CH_W{1'b0}};
      sel_q       <= 4'h0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_mask_q <= {NUM_CHANNELS{1'b0}};
      wreq_q      <= 1'b0;
      waddr_q     <= 14'h0000;
      wdata_q     <= 32'h0000_0000;
`ifdef PN_SWEEP_ACK_TIMEOUT_EN
      ack_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sel_q       <= pnseq_sel;
            ch_q        <= {CH_W{1'b0}};
            pass_mask_q <= {NUM_CHANNELS{1'b0}};
            fail_q      <= 1'b0;
            busy_q      <= 1'b1;
            wreq_q      <= 1'b1;
            waddr_q     <= cntrl3_addr(4'h0);
            wdata_q     <= pnseq_wdata(pnseq_sel);
`ifdef PN_SWEEP_ACK_TIMEOUT_EN
            ack_timeout_q <= 1'b0;
`endif
            state_q     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wreq_q  <= 1'b0;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (up_bus.up_wack) begin
            state_q <= ST_SETTLE;
          end
`ifdef PN_SWEEP_ACK_TIMEOUT_EN
          else if (tmr_zero) begin
            fail_q        <= 1'b1;
            ack_timeout_q <= 1'b1;
            state_q       <= ST_NEXT;
          end
`endif
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            if (ch_oos_d) begin
              // No lock: the check window is skipped entirely.
              fail_q  <= 1'b1;
              state_q <= ST_NEXT;
            end else begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (ch_oos_d || ch_err_d) begin
            fail_q <= 1'b1;
          end
          // The final window cycle still counts, so fold it in directly.
          if (tmr_zero) begin
            pass_mask_q[ch_q] <= !(fail_q || ch_oos_d || ch_err_d);
            state_q           <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          fail_q <= 1'b0;
          if (ch_last_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            ch_q    <= ch_nxt_d;
            wreq_q  <= 1'b1;
            waddr_q <= cntrl3_addr(4'(ch_nxt_d));
            wdata_q <= pnseq_wdata(sel_q);
            state_q <= ST_WRITE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wreq_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass_mask       = pass_mask_q;
  assign up_bus.up_wreq  = wreq_q;
  assign up_bus.up_waddr = waddr_q;
  assign up_bus.up_wdata = wdata_q;
`ifdef PN_SWEEP_ACK_TIMEOUT_EN
  assign ack_timeout = ack_timeout_q;
`else
  assign ack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_adc_jesd204_pn_sweep.sv
// Self-checking bench for axi_adc_jesd204_pn_sweep. A sweep-level model
// predicts write cycles, done cycle, pass mask and ack timeout from the
// per-channel ack latencies and the oos/err waveforms the bench drives.
module tb_axi_adc_jesd204_pn_sweep;

  localparam int NCH  = 4;
  localparam int SET  = 8;
  localparam int CHK  = 16;
  localparam int MAXC = 512;

  logic           up_clk = 1'b0;
  logic           up_rstn;
  logic           start;
  logic [3:0]     pnseq_sel;
  logic           busy;
  logic           done;
  logic [NCH-1:0] pass_mask;
  logic [NCH-1:0] oos;
  logic [NCH-1:0] err;
  logic           ack_timeout;

  axi_adc_jesd204_pn_sweep_if bus();

  axi_adc_jesd204_pn_sweep #(
    .NUM_CHANNELS  (NCH),
    .SETTLE_CYCLES (SET),
    .CHECK_CYCLES  (CHK)
  ) dut (
    .up_clk        (up_clk),
    .up_rstn       (up_rstn),
    .start         (start),
    .pnseq_sel     (pnseq_sel),
    .busy          (busy),
    .done          (done),
    .pass_mask     (pass_mask),
    .up_bus        (bus),
    .up_adc_pn_oos (oos),
    .up_adc_pn_err (err),
    .ack_timeout   (ack_timeout)
  );

  always #5 up_clk = ~up_clk;

  int checks;
  int errors;

  // Stimulus description: waveforms indexed by cycle since start, ack latency
  // per write (0 = never acknowledged).
  logic [NCH-1:0] oos_w [MAXC];
  logic [NCH-1:0] err_w [MAXC];
  int             lat   [NCH];

  // Model predictions.
  int             exp_w [NCH];
  int             exp_done;
  logic [NCH-1:0] exp_mask;
  logic           exp_to;

  task automatic clear_waves();
    for (int i = 0; i < MAXC; i++) begin
      oos_w[i] = '0;
      err_w[i] = '0;
    end
  endtask

  // Sweep model: start in cycle 0, first write in cycle 1. Per channel the
  // write takes 1 cycle, the ack arrives lat cycles later, lock is judged in
  // the last settle cycle, then CHECK cycles of observation and 1 NEXT cycle.
  task automatic model_sweep();
    int   w;
    int   se;
    logic bad;
    w = 1;
    exp_mask = '0;
    exp_to = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      exp_w[n] = w;
      if (lat[n] == 0) begin
        exp_to = 1'b1;
        w = w + 64 + 2;
      end else begin
        se = w + lat[n] + SET;
        if (oos_w[se][n]) begin
          w = se + 2;
        end else begin
          bad = 1'b0;
          for (int cc = se + 1; cc <= se + CHK; cc++)
            if (oos_w[cc][n] || err_w[cc][n]) bad = 1'b1;
          exp_mask[n] = !bad;
          w = se + CHK + 2;
        end
      end
    end
    exp_done = w;
  endtask

  // Runs one sweep cycle by cycle: observe outputs at the falling edge, then
  // drive the inputs for that cycle. abort_at >= 0 resets the DUT mid-sweep.
  task automatic run_sweep(input string tag, input logic [3:0] sel, input int extra_start,
                           input int spur_wack, input int abort_at);
    int          k;
    int          wack_at;
    int          done_cnt;
    int          limit;
    logic [13:0] ea;
    logic        exp_busy;
    k = 0; wack_at = -1; done_cnt = 0; limit = exp_done + 4; ea = 14'h0;
    for (int c = 0; c <= limit; c++) begin
      @(negedge up_clk);
      exp_busy = (c >= 1) && (c < exp_done);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy @%0d: got %b expected %b", tag, c, busy, exp_busy);
      end
      if (bus.up_wreq === 1'b1) begin
        checks++;
        if (k >= NCH || c != exp_w[k]) begin
          errors++;
          $display("FAIL %s wreq_cycle write %0d: got cycle %0d expected %0d", tag, k, c,
                   (k < NCH) ? exp_w[k] : -1);
        end else begin
          ea = 14'(32'h100 + 32'(k) * 32'd16 + 32'h6);
          checks++;
          if (bus.up_waddr !== ea) begin
            errors++;
            $display("FAIL %s waddr write %0d: got %h expected %h", tag, k, bus.up_waddr, ea);
          end
          checks++;
          if (bus.up_wdata !== {12'h000, sel, 16'h0000}) begin
            errors++;
            $display("FAIL %s wdata write %0d: got %h expected %h", tag, k, bus.up_wdata,
                     {12'h000, sel, 16'h0000});
          end
          wack_at = (lat[k] > 0) ? c + lat[k] : -1;
        end
        k++;
      end
      if (c == wack_at) begin
        checks++;
        if (bus.up_wreq !== 1'b0 || bus.up_waddr !== ea) begin
          errors++;
          $display("FAIL %s wait_ack_hold @%0d: got wreq=%b addr=%h expected wreq=0 addr=%h",
                   tag, c, bus.up_wreq, bus.up_waddr, ea);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (c != exp_done) begin
          errors++;
          $display("FAIL %s done_cycle: got %0d expected %0d", tag, c, exp_done);
        end
        checks++;
        if (pass_mask !== exp_mask) begin
          errors++;
          $display("FAIL %s pass_mask: got %h expected %h", tag, pass_mask, exp_mask);
        end
        checks++;
        if (ack_timeout !== exp_to) begin
          errors++;
          $display("FAIL %s ack_timeout: got %b expected %b", tag, ack_timeout, exp_to);
        end
      end
      if (c == abort_at) begin
        checks++;
        if (pass_mask[0] !== exp_mask[0]) begin
          errors++;
          $display("FAIL %s pre_abort_mask0: got %b expected %b", tag, pass_mask[0], exp_mask[0]);
        end
        start = 1'b0; bus.up_wack = 1'b0; oos = '0; err = '0;
        up_rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.up_wreq, ack_timeout} !== 4'b0000 || pass_mask !== '0 ||
            bus.up_waddr !== 14'h0 || bus.up_wdata !== 32'h0) begin
          errors++;
          $display("FAIL %s abort_immediate: got busy=%b wreq=%b mask=%h addr=%h expected all 0",
                   tag, busy, bus.up_wreq, pass_mask, bus.up_waddr);
        end
        @(negedge up_clk);
        checks++;
        if ({busy, done, bus.up_wreq} !== 3'b000 || pass_mask !== '0) begin
          errors++;
          $display("FAIL %s abort_next_cycle: got busy=%b wreq=%b mask=%h expected all 0",
                   tag, busy, bus.up_wreq, pass_mask);
        end
        up_rstn = 1'b1;
        return;
      end
      start       = (c == 0) || (c == extra_start);
      pnseq_sel   = (c == 0) ? sel : 4'($urandom);
      bus.up_wack = (c == wack_at) || (c == spur_wack);
      oos         = oos_w[c];
      err         = err_w[c];
    end
    start = 1'b0; bus.up_wack = 1'b0; oos = '0; err = '0;
    checks++;
    if (k != NCH) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, k, NCH);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
    end
  endtask

  task automatic test_reset();
    up_rstn = 1'b0;
    repeat (3) @(negedge up_clk);
    checks++;
    if ({busy, done, bus.up_wreq, ack_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b wreq=%b to=%b expected 0", busy, done,
               bus.up_wreq, ack_timeout);
    end
    checks++;
    if (bus.up_waddr !== 14'h0 || bus.up_wdata !== 32'h0 || pass_mask !== '0) begin
      errors++;
      $display("FAIL reset_values: got addr=%h data=%h mask=%h expected 0", bus.up_waddr,
               bus.up_wdata, pass_mask);
    end
    up_rstn = 1'b1;
    repeat (2) @(negedge up_clk);
  endtask

`ifdef PN_SWEEP_ACK_TIMEOUT_EN
  task automatic test_ack_timeout();
    clear_waves();
    lat[0] = 0; lat[1] = 2; lat[2] = 2; lat[3] = 2;
    model_sweep();
    run_sweep("ack_timeout", 4'h3, -1, -1, -1);
  endtask
`endif

  task automatic test_basic();
    clear_waves();
    for (int n = 0; n < NCH; n++) lat[n] = 2;
    model_sweep();
    run_sweep("basic", 4'h1, -1, -1, -1);
  endtask

  task automatic test_lock_fail();
    clear_waves();
    for (int i = 0; i < MAXC; i++) oos_w[i][2] = 1'b1;
    for (int n = 0; n < NCH; n++) lat[n] = 2;
    model_sweep();
    run_sweep("lock_fail", 4'h5, -1, -1, -1);
  endtask

  task automatic test_single_err();
    clear_waves();
    for (int n = 0; n < NCH; n++) lat[n] = 2;
    model_sweep();
    err_w[exp_w[1] + lat[1] + SET + 8][1] = 1'b1;
    model_sweep();
    run_sweep("single_err", 4'hA, -1, -1, -1);
  endtask

  task automatic test_busy_guard_reset();
    clear_waves();
    for (int n = 0; n < NCH; n++) lat[n] = 3;
    model_sweep();
    // Extra start during channel 1 and another coincident with done.
    run_sweep("busy_guard", 4'h7, exp_w[1] + 3, -1, -1);
    run_sweep("busy_guard_done", 4'h2, exp_done, -1, -1);
    // Second sweep aborted by reset during channel 1 SETTLE.
    run_sweep("reset_abort", 4'h9, -1, -1, exp_w[1] + lat[1] + 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge up_clk);
      checks++;
      if (busy !== 1'b0 || bus.up_wreq !== 1'b0) begin
        errors++;
        $display("FAIL post_abort_idle @%0d: got busy=%b wreq=%b expected 0", i, busy,
                 bus.up_wreq);
      end
    end
  endtask

  task automatic test_random();
    int kind;
    for (int it = 0; it < 6; it++) begin
      clear_waves();
      for (int n = 0; n < NCH; n++) begin
        lat[n] = $urandom_range(1, 4);
        kind = $urandom_range(0, 4);
        case (kind)
          1: for (int i = 0; i < MAXC; i++) oos_w[i][n] = 1'b1;
          2: err_w[$urandom_range(1, 130)][n] = 1'b1;
          3: oos_w[$urandom_range(1, 130)][n] = 1'b1;
          default: ;
        endcase
      end
      model_sweep();
      // A stray ack during channel 0 SETTLE must be ignored.
      run_sweep("random", 4'($urandom), -1, exp_w[0] + lat[0] + 2, -1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    up_rstn = 1'b0;
    start = 1'b0;
    pnseq_sel = 4'h0;
    bus.up_wack = 1'b0;
    oos = '0;
    err = '0;
    clear_waves();
    for (int n = 0; n < NCH; n++) lat[n] = 2;
    test_reset();
`ifdef PN_SWEEP_ACK_TIMEOUT_EN
    test_ack_timeout();
`endif
    test_basic();
    test_lock_fail();
    test_single_err();
    test_busy_guard_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
